dual_issue_ctrl: RTL

//  Issue/hazard sequencer for the dual-issue front end. Decides each cycle whether the

---
 rtl/dual_issue_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: issue/hazard sequencer for the dual-issue IF/ID stage.
// Ports: clk, reset (sync, active-high); valid_ID, dep_raw1, dep_raw2, dep_pair,
// branch_mispredict, stall_ext in; pc_stall, ifid_stall, flush, issue1, issue2,
// state_o[1:0] out. Optional ISSUE_STATS_EN adds dual_cnt[31:0] and stall_cnt[31:0].
module dual_issue_ctrl #(
    parameter int HAZ_STALL_CYCLES = 6,
    parameter int FLUSH_CYCLES     = 2,
    parameter int CNT_W            = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_ID,
    input  logic       dep_raw1,
    input  logic       dep_raw2,
    input  logic       dep_pair,
    input  logic       branch_mispredict,
    input  logic       stall_ext,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       flush,
    output logic       issue1,
    output logic       issue2,
`ifdef ISSUE_STATS_EN
    output logic [31:0] dual_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0] state_o
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_SPLIT = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;
    localparam logic [CNT_W-1:0] HAZ_LOAD   = CNT_W'(HAZ_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // cnt holds the cycles still to be spent in STALL/FLUSH, the current one included;
    // the entry cycle in RUN already counts, so the load value is the length minus one.
    logic last;
    assign last = cnt_q <= ONE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        flush      = 1'b0;
        issue1     = 1'b0;
        issue2     = 1'b0;
        if (reset) begin
            state_d = S_RUN;
            cnt_d   = '0;
        end else if (branch_mispredict) begin
            flush   = 1'b1;
            state_d = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
            cnt_d   = (FLUSH_CYCLES == 1) ? '0 : FLUSH_LOAD;
        end else if (stall_ext) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            flush      = state_q == S_FLUSH;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (valid_ID && dep_raw1) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        state_d    = (HAZ_STALL_CYCLES == 1) ? S_RUN : S_STALL;
                        cnt_d      = (HAZ_STALL_CYCLES == 1) ? '0 : HAZ_LOAD;
                    end else if (valid_ID && (dep_raw2 || dep_pair)) begin
                        issue1     = 1'b1;
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        state_d    = S_SPLIT;
                    end else begin
                        issue1 = valid_ID;
                        issue2 = valid_ID;
                    end
                end
                S_STALL: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    state_d    = last ? S_RUN : S_STALL;
                    cnt_d      = last ? '0 : cnt_q - ONE;
                end
                S_SPLIT: begin
                    pc_stall   = dep_raw2;
                    ifid_stall = dep_raw2;
                    issue2     = !dep_raw2;
                    state_d    = dep_raw2 ? S_SPLIT : S_RUN;
                end
                default: begin
                    flush   = 1'b1;
                    state_d = last ? S_RUN : S_FLUSH;
                    cnt_d   = last ? '0 : cnt_q - ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    assign state_o = reset ? S_RUN : state_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] dual_cnt_q, dual_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        dual_cnt_d  = reset ? '0 : dual_cnt_q + 32'((issue1 && issue2) && (dual_cnt_q != '1));
        stall_cnt_d = reset ? '0 : stall_cnt_q + 32'(pc_stall && (stall_cnt_q != '1));
    end
    always_ff @(posedge clk) begin
        dual_cnt_q  <= dual_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end
    assign dual_cnt  = dual_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule
